fir_ts_ctrl: RTL and testbench

Sequencer and coefficient manager for the 4:1 time-shared symmetric FIR datapath. It generates the phase select, the sample strobe and the symbol strobe that drive the time-shared multipliers. It holds the filter's folded coefficients in a double-buffered register bank, so software or a test host can reload taps while the filter runs. New taps swap in atomically on a sample boundary, so a partially updated filter is never presented to the datapath.

---
 rtl/fir_ts_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fir_ts_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ts_ctrl.sv
// Sequencer and double-buffered coefficient manager for the 4:1 time-shared symmetric FIR.
// Generates phase/sample/symbol strobes and swaps the tap banks atomically on a sample boundary.
module fir_ts_ctrl #(
  parameter int WIDTH  = 18,
  parameter int NCOEF  = 51,
  parameter int PHASES = 4,
  parameter int SPS    = 4,
  parameter int AW     = 6
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    coef_wr_valid,
  output logic                    coef_wr_ready,
  input  logic [AW-1:0]           coef_wr_addr,
  input  logic signed [WIDTH-1:0] coef_wr_data,
  input  logic                    coef_commit,
  output logic                    commit_done,
  output logic                    wr_err,
  input  logic                    err_clr,
  input  logic [AW-1:0]           coef_rd_addr,
  output logic signed [WIDTH-1:0] coef_rd_data,
  output logic [1:0]              phase,
  output logic                    sam_clk_en,
  output logic                    sym_clk_en,
  output logic                    bank_sel
);

  localparam int SW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [1:0]    PHASE_LAST = 2'(PHASES - 1);
  localparam logic [SW-1:0] SAM_LAST   = SW'(SPS - 1);
  localparam logic [AW:0]   NCOEF_LIM  = (AW + 1)'(NCOEF);

  typedef enum logic [1:0] {IDLE, LOAD, PENDING} loadState_e;

  logic [1:0]    phase_q, phase_d;
  logic [SW-1:0] samCnt_q, samCnt_d;
  logic          bankSel_q, bankSel_d;
  logic          commitDone_q, commitDone_d;
  logic          wrErr_q, wrErr_d;
  loadState_e    state_q, state_d;

  logic signed [WIDTH-1:0] bank0_q [NCOEF];
  logic signed [WIDTH-1:0] bank1_q [NCOEF];

  logic wrAccept, wrAddrOk, rdAddrOk, commitAccept, swapGo;

  assign wrAddrOk     = {1'b0, coef_wr_addr} < NCOEF_LIM;
  assign rdAddrOk     = {1'b0, coef_rd_addr} < NCOEF_LIM;
  assign wrAccept     = coef_wr_valid && coef_wr_ready;
  assign commitAccept = coef_commit && coef_wr_ready;

  assign sam_clk_en = enable && (phase_q == PHASE_LAST);
  assign sym_clk_en = sam_clk_en && (samCnt_q == SAM_LAST);

  always_comb begin
    phase_d      = phase_q;
    samCnt_d     = samCnt_q;
    bankSel_d    = bankSel_q;
    commitDone_d = swapGo;
    wrErr_d      = wrErr_q;
    if (enable) begin
      phase_d = (phase_q == PHASE_LAST) ? 2'd0 : phase_q + 2'd1;
    end
    if (sam_clk_en) begin
      samCnt_d = (samCnt_q == SAM_LAST) ? '0 : samCnt_q + SW'(1);
    end
    if (swapGo) begin
      bankSel_d = ~bankSel_q;
    end
    // A bad write in the same cycle as err_clr keeps the flag set.
    if (wrAccept && !wrAddrOk) begin
      wrErr_d = 1'b1;
    end else if (err_clr) begin
      wrErr_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= '0;
      samCnt_q     <= '0;
      bankSel_q    <= 1'b0;
      commitDone_q <= 1'b0;
      wrErr_q      <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      samCnt_q     <= samCnt_d;
      bankSel_q    <= bankSel_d;
      commitDone_q <= commitDone_d;
      wrErr_q      <= wrErr_d;
    end
  end

  // Writes always target the bank that is not currently being read.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCOEF; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
    end else if (wrAccept && wrAddrOk) begin
      if (bankSel_q) begin
        bank0_q[coef_wr_addr] <= coef_wr_data;
      end else begin
        bank1_q[coef_wr_addr] <= coef_wr_data;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (commitAccept) begin
          state_d = PENDING;
        end else if (wrAccept) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (commitAccept) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (sam_clk_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coef_wr_ready = (state_q != PENDING);
    swapGo        = (state_q == PENDING) && sam_clk_en;
  end

  always_comb begin
    coef_rd_data = '0;
    if (rdAddrOk) begin
      coef_rd_data = bankSel_q ? bank1_q[coef_rd_addr] : bank0_q[coef_rd_addr];
    end
  end

  assign phase       = phase_q;
  assign bank_sel    = bankSel_q;
  assign commit_done = commitDone_q;
  assign wr_err      = wrErr_q;

endmodule

// File: tb/tb_fir_ts_ctrl.sv
// Directed self-checking bench for fir_ts_ctrl: strobe sequencing, bank loading/swap,
// write error flag, enable stalls and asynchronous reset during a pending commit.
module tb_fir_ts_ctrl;

  logic               sys_clk;
  logic               reset_n;
  logic               enable;
  logic               coef_wr_valid;
  logic               coef_wr_ready;
  logic [5:0]         coef_wr_addr;
  logic signed [17:0] coef_wr_data;
  logic               coef_commit;
  logic               commit_done;
  logic               wr_err;
  logic               err_clr;
  logic [5:0]         coef_rd_addr;
  logic signed [17:0] coef_rd_data;
  logic [1:0]         phase;
  logic               sam_clk_en;
  logic               sym_clk_en;
  logic               bank_sel;

  int compared   = 0;
  int mismatched = 0;

  fir_ts_ctrl dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .coef_wr_valid (coef_wr_valid),
    .coef_wr_ready (coef_wr_ready),
    .coef_wr_addr  (coef_wr_addr),
    .coef_wr_data  (coef_wr_data),
    .coef_commit   (coef_commit),
    .commit_done   (commit_done),
    .wr_err        (wr_err),
    .err_clr       (err_clr),
    .coef_rd_addr  (coef_rd_addr),
    .coef_rd_data  (coef_rd_data),
    .phase         (phase),
    .sam_clk_en    (sam_clk_en),
    .sym_clk_en    (sym_clk_en),
    .bank_sel      (bank_sel)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic nextCycle();
    @(negedge sys_clk);
  endtask

  // Leaves the bench at a falling edge with reset just released and all inputs idle.
  task automatic applyReset();
    reset_n       = 1'b0;
    enable        = 1'b0;
    coef_wr_valid = 1'b0;
    coef_wr_addr  = '0;
    coef_wr_data  = '0;
    coef_commit   = 1'b0;
    err_clr       = 1'b0;
    coef_rd_addr  = '0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    applyReset();
    coef_rd_addr = 6'd50;
    #1;
    compared++;
    if ({phase, sam_clk_en, sym_clk_en} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_seq: got phase=%0d sam=%0b sym=%0b, expected 0 0 0", phase, sam_clk_en, sym_clk_en);
    end
    compared++;
    if ({bank_sel, commit_done, wr_err, coef_wr_ready} !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got bank=%0b done=%0b err=%0b rdy=%0b, expected 0 0 0 1", bank_sel, commit_done, wr_err, coef_wr_ready);
    end
    compared++;
    if (coef_rd_data !== 18'sd0) begin
      mismatched++;
      $display("[TB] FAIL reset_rd: got %0d expected 0", coef_rd_data);
    end
  endtask

  task automatic test_sequencing();
    logic [1:0] expPh;
    logic       expSam, expSym;
    applyReset();
    for (int k = 1; k <= 32; k++) begin
      if (k > 1) nextCycle();
      enable = 1'b1;
      #1;
      expPh  = 2'((k - 1) % 4);
      expSam = (k % 4) == 0;
      expSym = (k % 16) == 0;
      compared++;
      if ({phase, sam_clk_en, sym_clk_en} !== {expPh, expSam, expSym}) begin
        mismatched++;
        $display("[TB] FAIL seq_cycle%0d: got phase=%0d sam=%0b sym=%0b, expected %0d %0b %0b", k, phase, sam_clk_en, sym_clk_en, expPh, expSam, expSym);
      end
    end
  endtask

  task automatic test_load_commit();
    applyReset();
    coef_rd_addr  = 6'd50;
    coef_wr_valid = 1'b1;
    coef_wr_addr  = 6'd0;
    coef_wr_data  = 18'sd73;
    nextCycle();
    coef_wr_addr = 6'd50;
    coef_wr_data = 18'sd39137;
    #1;
    compared++;
    if (coef_wr_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL load_ready: got %0b expected 1", coef_wr_ready);
    end
    nextCycle();
    coef_wr_valid = 1'b0;
    enable        = 1'b1;
    #1;
    compared++;
    if (coef_rd_data !== 18'sd0) begin
      mismatched++;
      $display("[TB] FAIL load_shadow_hidden: got %0d expected 0", coef_rd_data);
    end
    nextCycle();
    coef_commit = 1'b1;
    #1;
    compared++;
    if ({phase, coef_wr_ready} !== {2'd1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL commit_phase1: got phase=%0d rdy=%0b expected 1 1", phase, coef_wr_ready);
    end
    nextCycle();
    coef_commit = 1'b0;
    #1;
    compared++;
    if ({phase, coef_wr_ready, bank_sel} !== {2'd2, 1'b0, 1'b0} || coef_rd_data !== 18'sd0) begin
      mismatched++;
      $display("[TB] FAIL pend_phase2: got phase=%0d rdy=%0b bank=%0b rd=%0d expected 2 0 0 0", phase, coef_wr_ready, bank_sel, coef_rd_data);
    end
    nextCycle();
    #1;
    compared++;
    if ({sam_clk_en, bank_sel, commit_done} !== 3'b100 || coef_rd_data !== 18'sd0) begin
      mismatched++;
      $display("[TB] FAIL pend_phase3: got sam=%0b bank=%0b done=%0b rd=%0d expected 1 0 0 0", sam_clk_en, bank_sel, commit_done, coef_rd_data);
    end
    nextCycle();
    #1;
    compared++;
    if ({bank_sel, commit_done, coef_wr_ready} !== 3'b111 || coef_rd_data !== 18'sd39137) begin
      mismatched++;
      $display("[TB] FAIL swap_a50: got bank=%0b done=%0b rdy=%0b rd=%0d expected 1 1 1 39137", bank_sel, commit_done, coef_wr_ready, coef_rd_data);
    end
    coef_rd_addr = 6'd0;
    #1;
    compared++;
    if (coef_rd_data !== 18'sd73) begin
      mismatched++;
      $display("[TB] FAIL swap_a0: got %0d expected 73", coef_rd_data);
    end
    coef_rd_addr = 6'd51;
    #1;
    compared++;
    if (coef_rd_data !== 18'sd0) begin
      mismatched++;
      $display("[TB] FAIL rd_out_of_range: got %0d expected 0", coef_rd_data);
    end
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      #1;
      compared++;
      if ({commit_done, bank_sel} !== 2'b01) begin
        mismatched++;
        $display("[TB] FAIL done_single_pulse%0d: got done=%0b bank=%0b expected 0 1", i, commit_done, bank_sel);
      end
    end
  endtask

  task automatic test_back_to_back();
    applyReset();
    enable        = 1'b1;
    coef_rd_addr  = 6'd5;
    coef_wr_valid = 1'b1;
    coef_wr_addr  = 6'd5;
    coef_wr_data  = 18'sd1000;
    nextCycle();
    coef_wr_valid = 1'b0;
    nextCycle();
    nextCycle();
    coef_commit = 1'b1;
    #1;
    compared++;
    if ({sam_clk_en, coef_wr_ready} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL b2b_commit_on_sam: got sam=%0b rdy=%0b expected 1 1", sam_clk_en, coef_wr_ready);
    end
    nextCycle();
    coef_commit   = 1'b0;
    coef_wr_valid = 1'b1;
    coef_wr_data  = 18'sd2222;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nextCycle();
      #1;
      compared++;
      if ({phase, coef_wr_ready, bank_sel, commit_done} !== {2'(i), 3'b000}) begin
        mismatched++;
        $display("[TB] FAIL b2b_pending%0d: got phase=%0d rdy=%0b bank=%0b done=%0b expected %0d 0 0 0", i, phase, coef_wr_ready, bank_sel, commit_done, i);
      end
    end
    nextCycle();
    coef_wr_valid = 1'b0;
    coef_commit   = 1'b1;
    #1;
    compared++;
    if ({bank_sel, commit_done} !== 2'b11 || coef_rd_data !== 18'sd1000) begin
      mismatched++;
      $display("[TB] FAIL b2b_swap: got bank=%0b done=%0b rd=%0d expected 1 1 1000", bank_sel, commit_done, coef_rd_data);
    end
    nextCycle();
    coef_commit = 1'b0;
    nextCycle();
    nextCycle();
    nextCycle();
    #1;
    compared++;
    if ({bank_sel, commit_done} !== 2'b01 || coef_rd_data !== 18'sd0) begin
      mismatched++;
      $display("[TB] FAIL b2b_empty_commit: got bank=%0b done=%0b rd=%0d expected 0 1 0", bank_sel, commit_done, coef_rd_data);
    end
  endtask

  task automatic test_wr_err();
    applyReset();
    coef_rd_addr  = 6'd51;
    coef_wr_valid = 1'b1;
    coef_wr_addr  = 6'd51;
    coef_wr_data  = 18'h155;
    #1;
    compared++;
    if (wr_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL err_before: got %0b expected 0", wr_err);
    end
    nextCycle();
    coef_wr_valid = 1'b0;
    #1;
    compared++;
    if ({wr_err, bank_sel} !== 2'b10 || coef_rd_data !== 18'sd0) begin
      mismatched++;
      $display("[TB] FAIL err_set: got err=%0b bank=%0b rd=%0d expected 1 0 0", wr_err, bank_sel, coef_rd_data);
    end
    nextCycle();
    #1;
    compared++;
    if (wr_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL err_sticky: got %0b expected 1", wr_err);
    end
    err_clr = 1'b1;
    nextCycle();
    err_clr = 1'b0;
    #1;
    compared++;
    if (wr_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL err_clear: got %0b expected 0", wr_err);
    end
    coef_wr_valid = 1'b1;
    coef_wr_addr  = 6'd63;
    err_clr       = 1'b1;
    nextCycle();
    coef_wr_valid = 1'b0;
    err_clr       = 1'b0;
    #1;
    compared++;
    if (wr_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL err_set_wins: got %0b expected 1", wr_err);
    end
  endtask

  task automatic test_enable_stall();
    applyReset();
    enable        = 1'b1;
    coef_rd_addr  = 6'd10;
    coef_wr_valid = 1'b1;
    coef_wr_addr  = 6'd10;
    coef_wr_data  = -18'sd500;
    coef_commit   = 1'b1;
    nextCycle();
    coef_wr_valid = 1'b0;
    coef_commit   = 1'b0;
    enable        = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) nextCycle();
      #1;
      compared++;
      if ({phase, sam_clk_en, sym_clk_en, bank_sel, coef_wr_ready} !== {2'd1, 4'b0000} || coef_rd_data !== 18'sd0) begin
        mismatched++;
        $display("[TB] FAIL stall%0d: got phase=%0d sam=%0b sym=%0b bank=%0b rdy=%0b rd=%0d expected 1 0 0 0 0 0", i, phase, sam_clk_en, sym_clk_en, bank_sel, coef_wr_ready, coef_rd_data);
      end
    end
    nextCycle();
    enable = 1'b1;
    nextCycle();
    nextCycle();
    #1;
    compared++;
    if ({phase, sam_clk_en, bank_sel} !== {2'd3, 2'b10}) begin
      mismatched++;
      $display("[TB] FAIL resume_sam: got phase=%0d sam=%0b bank=%0b expected 3 1 0", phase, sam_clk_en, bank_sel);
    end
    nextCycle();
    #1;
    compared++;
    if ({bank_sel, commit_done} !== 2'b11 || coef_rd_data !== -18'sd500) begin
      mismatched++;
      $display("[TB] FAIL resume_swap: got bank=%0b done=%0b rd=%0d expected 1 1 -500", bank_sel, commit_done, coef_rd_data);
    end
  endtask

  task automatic test_reset_pending();
    int pulses;
    applyReset();
    enable        = 1'b1;
    coef_rd_addr  = 6'd50;
    coef_wr_valid = 1'b1;
    coef_wr_addr  = 6'd60;
    nextCycle();
    coef_wr_addr = 6'd50;
    coef_wr_data = 18'sd39137;
    coef_commit  = 1'b1;
    nextCycle();
    coef_wr_valid = 1'b0;
    coef_commit   = 1'b0;
    #1;
    compared++;
    if ({phase, wr_err, coef_wr_ready} !== {2'd2, 2'b10}) begin
      mismatched++;
      $display("[TB] FAIL prereset: got phase=%0d err=%0b rdy=%0b expected 2 1 0", phase, wr_err, coef_wr_ready);
    end
    #1;
    reset_n = 1'b0;
    #1;
    compared++;
    if ({phase, sam_clk_en, sym_clk_en, bank_sel, commit_done, wr_err, coef_wr_ready} !== {2'd0, 6'b000001} || coef_rd_data !== 18'sd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got phase=%0d sam=%0b sym=%0b bank=%0b done=%0b err=%0b rdy=%0b rd=%0d expected 0 0 0 0 0 0 1 0", phase, sam_clk_en, sym_clk_en, bank_sel, commit_done, wr_err, coef_wr_ready, coef_rd_data);
    end
    nextCycle();
    reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (commit_done === 1'b1) pulses++;
      compared++;
      if (bank_sel !== 1'b0 || coef_rd_data !== 18'sd0) begin
        mismatched++;
        $display("[TB] FAIL post_reset%0d: got bank=%0b rd=%0d expected 0 0", i, bank_sel, coef_rd_data);
      end
      nextCycle();
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++;
      $display("[TB] FAIL aborted_commit_done: got %0d pulses expected 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_sequencing();
    test_load_commit();
    test_back_to_back();
    test_wr_err();
    test_enable_stall();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
